jk_ff_bank: RTL and testbench

Parametrised bank of WIDTH edge-triggered flip-flops with a shared, runtime-selectable mode: per-bit JK, D, T, or whole-word binary up/down counter. It generalises the single-bit JK flip-flop into a register that datapath and control logic use as a state register, a toggle mask, or an event counter. Q and Qbar are registered together and stay complementary in every cycle, including during reset.

---
 rtl/jk_ff_bank.sv | 65 ++++++
 tb/tb_jk_ff_bank.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/jk_ff_bank.sv
// rtl/jk_ff_bank.sv - bank of JK/D/T flip-flops with a shared mode and a whole-word up/down counter mode
module jk_ff_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             carry,
    output logic             changed
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_D     = 2'b01;
    localparam logic [1:0] MODE_T     = 2'b10;
    localparam logic [1:0] MODE_COUNT = 2'b11;

    logic [WIDTH-1:0] next_q;
    logic             wrap;

    always_comb begin
        next_q = q;
        wrap   = 1'b0;
        case (mode)
            // Characteristic equation: set where J and q=0, keep where K=0 and q=1.
            MODE_JK: next_q = (j & ~q) | (~k & q);
            MODE_D:  next_q = j;
            MODE_T:  next_q = q ^ j;
            MODE_COUNT: begin
                if (up) begin
                    next_q = q + WIDTH'(1);
                    wrap   = &q;
                end else begin
                    next_q = q - WIDTH'(1);
                    wrap   = ~|q;
                end
            end
            default: next_q = q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= RESET_VALUE;
            qbar    <= ~RESET_VALUE;
            carry   <= 1'b0;
            changed <= 1'b0;
        end else if (en) begin
            q       <= next_q;
            qbar    <= ~next_q;
            carry   <= wrap;
            changed <= (next_q != q);
        end else begin
            carry   <= 1'b0;
            changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jk_ff_bank.sv
// tb/tb_jk_ff_bank.sv - scoreboard bench for jk_ff_bank (WIDTH=4, RESET_VALUE=4'h5)
module tb_jk_ff_bank;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] j = 4'h0;
    logic [3:0] k = 4'h0;
    logic       up = 1'b0;
    logic [3:0] q;
    logic [3:0] qbar;
    logic       carry;
    logic       changed;

    typedef struct {
        logic [3:0] q;
        logic       carry;
        logic       changed;
    } exp_t;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] j;
        logic [3:0] k;
        logic       up;
        exp_t       e;
    } step_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    jk_ff_bank #(.WIDTH(4), .RESET_VALUE(4'h5)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .mode(mode),
        .j(j),
        .k(k),
        .up(up),
        .q(q),
        .qbar(qbar),
        .carry(carry),
        .changed(changed)
    );

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic do_edge(input step_t s);
        en   = s.en;
        mode = s.mode;
        j    = s.j;
        k    = s.k;
        up   = s.up;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        reset = 1'b1;
        sbq.push_back('{q: 4'h5, carry: 1'b0, changed: 1'b0});
        #1;
        e = sbq.pop_front();
        n_cmp += 4;
        if (q !== e.q)             begin n_bad++; $display("FAIL reset_q: got %h want %h", q, e.q); end
        if (qbar !== ~e.q)         begin n_bad++; $display("FAIL reset_qbar: got %h want %h", qbar, ~e.q); end
        if (carry !== e.carry)     begin n_bad++; $display("FAIL reset_carry: got %b want %b", carry, e.carry); end
        if (changed !== e.changed) begin n_bad++; $display("FAIL reset_changed: got %b want %b", changed, e.changed); end
        reset = 1'b0;
        #1;
        clk_run = 1'b1;
    endtask

    task automatic run_steps(input string name, input step_t steps[$]);
        exp_t e;
        foreach (steps[i]) begin
            sbq.push_back(steps[i].e);
            do_edge(steps[i]);
            n_cmp += 4;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL %s[%0d]_sb: scoreboard empty, got q=%h want an entry", name, i, q);
                continue;
            end
            e = sbq.pop_front();
            if (q !== e.q)             begin n_bad++; $display("FAIL %s[%0d]_q: got %h want %h", name, i, q, e.q); end
            if (qbar !== ~e.q)         begin n_bad++; $display("FAIL %s[%0d]_qbar: got %h want %h", name, i, qbar, ~e.q); end
            if (carry !== e.carry)     begin n_bad++; $display("FAIL %s[%0d]_carry: got %b want %b", name, i, carry, e.carry); end
            if (changed !== e.changed) begin n_bad++; $display("FAIL %s[%0d]_changed: got %b want %b", name, i, changed, e.changed); end
        end
    endtask

    task automatic test_jk;
        step_t s[$];
        s.push_back('{1'b1, 2'b00, 4'b1100, 4'b1010, 1'b0, '{4'hD, 1'b0, 1'b1}});
        run_steps("jk", s);
    endtask

    task automatic test_d_t;
        step_t s[$];
        s.push_back('{1'b1, 2'b01, 4'h9, 4'h0, 1'b0, '{4'h9, 1'b0, 1'b1}});
        s.push_back('{1'b1, 2'b10, 4'h3, 4'h0, 1'b0, '{4'hA, 1'b0, 1'b1}});
        s.push_back('{1'b0, 2'b10, 4'hF, 4'h0, 1'b0, '{4'hA, 1'b0, 1'b0}});
        run_steps("d_t", s);
    endtask

    task automatic test_count_up;
        step_t s[$];
        s.push_back('{1'b1, 2'b01, 4'hE, 4'h0, 1'b0, '{4'hE, 1'b0, 1'b1}});
        s.push_back('{1'b1, 2'b11, 4'h0, 4'h0, 1'b1, '{4'hF, 1'b0, 1'b1}});
        s.push_back('{1'b1, 2'b11, 4'h0, 4'h0, 1'b1, '{4'h0, 1'b1, 1'b1}});
        s.push_back('{1'b1, 2'b11, 4'h0, 4'h0, 1'b1, '{4'h1, 1'b0, 1'b1}});
        run_steps("count_up", s);
    endtask

    task automatic test_count_down;
        step_t s[$];
        // Loading the value already held must not flag a change.
        s.push_back('{1'b1, 2'b01, 4'h1, 4'h0, 1'b0, '{4'h1, 1'b0, 1'b0}});
        s.push_back('{1'b1, 2'b11, 4'h0, 4'h0, 1'b0, '{4'h0, 1'b0, 1'b1}});
        s.push_back('{1'b1, 2'b11, 4'h0, 4'h0, 1'b0, '{4'hF, 1'b1, 1'b1}});
        run_steps("count_down", s);
    endtask

    task automatic test_back_to_back;
        step_t s[$];
        // q=F: leaving COUNT for D on what would be a wrap gives no carry.
        s.push_back('{1'b1, 2'b01, 4'h0, 4'h0, 1'b1, '{4'h0, 1'b0, 1'b1}});
        s.push_back('{1'b1, 2'b00, 4'hF, 4'hF, 1'b0, '{4'hF, 1'b0, 1'b1}});
        s.push_back('{1'b1, 2'b00, 4'b0110, 4'b0110, 1'b0, '{4'h9, 1'b0, 1'b1}});
        s.push_back('{1'b1, 2'b00, 4'h0, 4'h0, 1'b0, '{4'h9, 1'b0, 1'b0}});
        run_steps("back_to_back", s);
    endtask

    task automatic test_reset_mid;
        step_t s[$];
        step_t r[$];
        step_t a[$];
        exp_t  e;
        s.push_back('{1'b1, 2'b01, 4'h7, 4'h0, 1'b0, '{4'h7, 1'b0, 1'b1}});
        s.push_back('{1'b1, 2'b11, 4'h0, 4'h0, 1'b1, '{4'h8, 1'b0, 1'b1}});
        run_steps("reset_mid_pre", s);
        #2;
        reset = 1'b1;
        sbq.push_back('{q: 4'h5, carry: 1'b0, changed: 1'b0});
        #1;
        e = sbq.pop_front();
        n_cmp += 4;
        if (q !== e.q)             begin n_bad++; $display("FAIL reset_mid_q: got %h want %h", q, e.q); end
        if (qbar !== ~e.q)         begin n_bad++; $display("FAIL reset_mid_qbar: got %h want %h", qbar, ~e.q); end
        if (carry !== e.carry)     begin n_bad++; $display("FAIL reset_mid_carry: got %b want %b", carry, e.carry); end
        if (changed !== e.changed) begin n_bad++; $display("FAIL reset_mid_changed: got %b want %b", changed, e.changed); end
        r.push_back('{1'b1, 2'b11, 4'h0, 4'h0, 1'b1, '{4'h5, 1'b0, 1'b0}});
        run_steps("reset_held", r);
        reset = 1'b0;
        a.push_back('{1'b1, 2'b11, 4'h0, 4'h0, 1'b1, '{4'h6, 1'b0, 1'b1}});
        run_steps("reset_after", a);
    endtask

    initial begin
        test_reset;
        test_jk;
        test_d_t;
        test_count_up;
        test_count_down;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
